// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and sizing helpers for the systolic array datapath.
package systolic_pkg;

  localparam int ELEM_W = 32;
  typedef logic [ELEM_W-1:0] elem_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // The output deskew latency equals the array width (DESKEW_LAT = N_SIZE).
  function automatic int deskew_lat(input int n_size);
    return n_size;
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// rtl/deskew_lane.sv - fixed-depth free-running shift chain for one output lane.
module deskew_lane
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout
);

  logic [DATAWIDTH-1:0] chain_q [DEPTH];
  logic [DATAWIDTH-1:0] chain_d [DEPTH];

  always_comb begin
    chain_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign dout = chain_q[DEPTH-1];

endmodule

// File: rtl/deskew_buffer.sv
// rtl/deskew_buffer.sv - realigns skewed systolic array columns into whole rows with tile framing.
// Optional DESKEW_ZERO_GATE_EN: out_data reads zero whenever out_valid is low.
module deskew_buffer
  import systolic_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int N_SIZE    = 32,
  parameter int ROWS      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [N_SIZE*DATAWIDTH-1:0] in_data,
  output logic                        out_valid,
  output logic [N_SIZE*DATAWIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        tile_done,
  output logic                        busy
);

  localparam int             LAT      = deskew_lat(N_SIZE);
  localparam int             CW       = clog2_min1(ROWS);
  localparam logic [CW-1:0]  LAST_ROW = CW'(ROWS - 1);

  logic [LAT-1:0]               vpipe_q, vpipe_d;
  logic [CW-1:0]                row_cnt_q, row_cnt_d;
  logic                         tile_done_q, tile_done_d;
  logic [N_SIZE*DATAWIDTH-1:0]  lane_out;

  // Lane j arrives j cycles late, so it needs N_SIZE-j stages to line up.
  for (genvar j = 0; j < N_SIZE; j++) begin : g_lane
    deskew_lane #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (N_SIZE - j)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .din  (in_data[j*DATAWIDTH +: DATAWIDTH]),
      .dout (lane_out[j*DATAWIDTH +: DATAWIDTH])
    );
  end

  assign out_valid = vpipe_q[LAT-1];
  assign out_last  = out_valid && (row_cnt_q == LAST_ROW);
  assign tile_done = tile_done_q;
  assign busy      = in_valid | (|vpipe_q);

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = in_valid;
    for (int i = 1; i < LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    row_cnt_d = row_cnt_q;
    if (out_valid) begin
      row_cnt_d = out_last ? '0 : row_cnt_q + 1'b1;
    end
    tile_done_d = out_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q     <= '0;
      row_cnt_q   <= '0;
      tile_done_q <= 1'b0;
    end else begin
      vpipe_q     <= vpipe_d;
      row_cnt_q   <= row_cnt_d;
      tile_done_q <= tile_done_d;
    end
  end

`ifdef DESKEW_ZERO_GATE_EN
  assign out_data = out_valid ? lane_out : '0;
`else
  assign out_data = lane_out;
`endif

endmodule

// File: tb/tb_deskew_buffer.sv
// tb/tb_deskew_buffer.sv - directed bench for deskew_buffer (N=4/ROWS=4 and N=1/ROWS=1) against a row-level model.
module tb_deskew_buffer;

  localparam int DW   = 32;
  localparam int N0   = 4;
  localparam int R0   = 4;
  localparam int N1   = 1;
  localparam int R1   = 1;
  localparam int MAXC = 100;
  localparam int SZ   = MAXC + 8;

  logic               clk;
  logic               rst;
  logic               in_valid0, in_valid1;
  logic [N0*DW-1:0]   in_data0, out_data0;
  logic [N1*DW-1:0]   in_data1, out_data1;
  logic               out_valid0, out_last0, tile_done0, busy0;
  logic               out_valid1, out_last1, tile_done1, busy1;

  bit          iv [2][SZ];
  logic [31:0] ld [2][SZ][4];
  bit          rs [SZ];

  int checks   = 0;
  int failures = 0;
  int beat     [2];
  bit prev_last[2];

  deskew_buffer #(.DATAWIDTH(DW), .N_SIZE(N0), .ROWS(R0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
    .out_valid(out_valid0), .out_data(out_data0), .out_last(out_last0),
    .tile_done(tile_done0), .busy(busy0)
  );

  deskew_buffer #(.DATAWIDTH(DW), .N_SIZE(N1), .ROWS(R1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .out_valid(out_valid1), .out_data(out_data1), .out_last(out_last1),
    .tile_done(tile_done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  task automatic add_row(input int inst, input int t, input logic [31:0] g);
    int n;
    n = (inst == 0) ? N0 : N1;
    iv[inst][t] = 1'b1;
    for (int j = 0; j < n; j++) ld[inst][t+j][j] = 32'h10 * j + g;
  endtask

  // A row entering at cycle t is lost if reset is sampled on any edge before it leaves.
  function automatic bit killed(input int t, input int len);
    for (int u = t; u < t + len; u++) if (rs[u]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_valid(input int inst, input int c, input int n);
    int t;
    t = c - n;
    if (t < 0) return 1'b0;
    return iv[inst][t] && !killed(t, n);
  endfunction

  function automatic bit exp_busy(input int inst, input int c, input int n);
    if (iv[inst][c]) return 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (c - k >= 0 && iv[inst][c-k] && !killed(c - k, k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_inst(input int inst, input int c);
    int n, r;
    bit ev, el, et;
    logic [127:0] ed, ad;
    logic av, al, at, ab;
    n  = (inst == 0) ? N0 : N1;
    r  = (inst == 0) ? R0 : R1;
    ev = exp_valid(inst, c, n);
    el = ev && (beat[inst] % r == r - 1);
    et = prev_last[inst] && !rs[c-1];
    ed = '0;
    if (ev) for (int j = 0; j < n; j++) ed[j*32 +: 32] = ld[inst][c-n+j][j];
    if (inst == 0) begin
      av = out_valid0; al = out_last0; at = tile_done0; ab = busy0; ad = 128'(out_data0);
    end else begin
      av = out_valid1; al = out_last1; at = tile_done1; ab = busy1; ad = 128'(out_data1);
    end
    chk($sformatf("out_valid%0d", inst), c, 128'(av), 128'(ev));
    chk($sformatf("out_last%0d", inst), c, 128'(al), 128'(el));
    chk($sformatf("tile_done%0d", inst), c, 128'(at), 128'(et));
    chk($sformatf("busy%0d", inst), c, 128'(ab), 128'(exp_busy(inst, c, n)));
`ifdef DESKEW_ZERO_GATE_EN
    chk($sformatf("out_data%0d", inst), c, ad, ed);
`else
    if (ev) chk($sformatf("out_data%0d", inst), c, ad, ed);
`endif
    if (ev) beat[inst]++;
    if (rs[c]) beat[inst] = 0;
    prev_last[inst] = el;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < SZ; c++)
        for (int j = 0; j < 4; j++) ld[i][c][j] = 32'hDEADBEEF;
    rs[0] = 1'b1; rs[1] = 1'b1; rs[15] = 1'b1; rs[62] = 1'b1;
    add_row(0, 4, 32'h0);
    for (int k = 0; k < 4; k++) add_row(0, 20 + k, 32'h1 + k);
    for (int k = 0; k < 4; k++) add_row(0, 40 + 3*k, 32'h5 + k);
    for (int k = 0; k < 3; k++) add_row(0, 60 + k, 32'h9 + k);
    for (int k = 0; k < 4; k++) add_row(0, 70 + k, 32'hC + k);
    add_row(1, 4, 32'h100); add_row(1, 5, 32'h101); add_row(1, 6, 32'h102);
    add_row(1, 10, 32'h1A0); add_row(1, 30, 32'h130);
    add_row(1, 62, 32'h162); add_row(1, 63, 32'h163);
    beat[0] = 0; beat[1] = 0; prev_last[0] = 0; prev_last[1] = 0;
    rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; in_data0 = '0; in_data1 = '0;

    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      rst       = rs[c];
      in_valid0 = iv[0][c];
      in_valid1 = iv[1][c];
      for (int j = 0; j < N0; j++) in_data0[j*32 +: 32] = ld[0][c][j];
      in_data1 = ld[1][c][0];
      #1;
      if (c >= 1) begin
        check_inst(0, c);
        check_inst(1, c);
        if (c == 2)  chk("reset_out_valid0", c, 128'(out_valid0), 128'(1'b0));
        if (c == 7)  chk("t1_early_valid", c, 128'(out_valid0), 128'(1'b0));
        if (c == 8)  chk("t1_valid", c, 128'(out_valid0), 128'(1'b1));
        if (c == 8)  chk("t1_lane_data", c, 128'(out_data0), {32'h30, 32'h20, 32'h10, 32'h00});
        if (c == 9)  chk("t1_late_valid", c, 128'(out_valid0), 128'(1'b0));
`ifdef DESKEW_ZERO_GATE_EN
        if (c == 9)  chk("t5_zero_gate", c, 128'(out_data0), 128'h0);
`endif
        if (c == 26) chk("t2_not_last", c, 128'(out_last0), 128'(1'b0));
        if (c == 27) chk("t2_last", c, 128'(out_last0), 128'(1'b1));
        if (c == 28) chk("t2_tile_done", c, 128'(tile_done0), 128'(1'b1));
        if (c == 53) chk("t3_last_gapped", c, 128'(out_last0), 128'(1'b1));
        if (c == 63) chk("t4_busy_after_rst", c, 128'(busy0), 128'(1'b0));
        if (c == 65) chk("t4_flushed", c, 128'(out_valid0), 128'(1'b0));
        if (c == 77) chk("t4_next_tile_last", c, 128'(out_last0), 128'(1'b1));
        if (c == 5)  chk("t6_last_each", c, 128'(out_last1), 128'(1'b1));
        if (c == 6)  chk("t6_tile_done", c, 128'(tile_done1), 128'(1'b1));
        if (c == 11) chk("t6_data", c, 128'(out_data1), 128'h1A0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
